// File: rtl/vga_text_arbiter.sv
// Round-robin owner of the 8-digit VGA hex line; grant and digits change only at frame start.
// Optional owner-index tag in s1 when VGA_TEXT_OWNER_TAG_EN is defined.
module vga_text_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter int          HOLD_FRAMES = 60,
  parameter logic [31:0] IDLE_CODE   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vs,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   frame_tick,
  output logic [3:0]             s1,
  output logic [3:0]             s2,
  output logic [3:0]             s3,
  output logic [3:0]             s4,
  output logic [3:0]             s5,
  output logic [3:0]             s6,
  output logic [3:0]             s7,
  output logic [3:0]             s8
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [31:0]        word_q, word_d;
  logic               vs_q, tick_q;
  logic               fs;

  logic [NUM_REQ-1:0] others;
  logic               pick_vld;
  logic [PW-1:0]      pick_idx;
  logic               owner_req;

  assign fs = vs_q & ~vs;

  function automatic logic [31:0] idle_word();
`ifdef VGA_TEXT_OWNER_TAG_EN
    return {4'hF, IDLE_CODE[27:0]};
`else
    return IDLE_CODE;
`endif
  endfunction

  function automatic logic [31:0] owner_word(input logic [PW-1:0] idx);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == PW'(i)) w = req_data[32*i +: 32];
    end
`ifdef VGA_TEXT_OWNER_TAG_EN
    return {4'(idx), w[27:0]};
`else
    return w;
`endif
  endfunction

  // Only requesters other than the current owner compete; in IDLE grant_q is zero so all compete.
  always_comb begin
    int idx;
    others   = req & ~grant_q;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(rr_q) + off) % NUM_REQ;
      if (!pick_vld && others[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PW'(idx);
      end
    end
  end

  assign owner_req = |(req & grant_q);

  always_comb begin
    logic take;
    logic keep;
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    word_d  = word_q;
    take    = 1'b0;
    keep    = 1'b0;
    if (fs) begin
      case (state_q)
        IDLE: take = pick_vld;
        HOLD: begin
          if (!owner_req)                                   take = pick_vld;
          else if (hold_q == HW'(HOLD_FRAMES) && pick_vld) take = 1'b1;
          else                                              keep = 1'b1;
        end
      endcase
      if (take) begin
        state_d = HOLD;
        grant_d = NUM_REQ'(1) << pick_idx;
        hold_d  = HW'(1);
        rr_d    = pick_idx;
        word_d  = owner_word(pick_idx);
      end else if (keep) begin
        // rr_q always names the current owner while in HOLD
        if (hold_q < HW'(HOLD_FRAMES)) hold_d = hold_q + HW'(1);
        word_d = owner_word(rr_q);
      end else begin
        state_d = IDLE;
        grant_d = '0;
        word_d  = idle_word();
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      hold_q  <= '0;
      rr_q    <= PW'(NUM_REQ - 1);
      word_q  <= idle_word();
      vs_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      rr_q    <= rr_d;
      word_q  <= word_d;
      vs_q    <= vs;
      tick_q  <= fs;
    end
  end

  assign grant      = grant_q;
  assign frame_tick = tick_q;
  assign s1 = word_q[31:28];
  assign s2 = word_q[27:24];
  assign s3 = word_q[23:20];
  assign s4 = word_q[19:16];
  assign s5 = word_q[15:12];
  assign s6 = word_q[11:8];
  assign s7 = word_q[7:4];
  assign s8 = word_q[3:0];

endmodule

// File: doc/vga_text_arbiter.md
Name: vga_text_arbiter

Overview:
- Shares the 8-digit VGA hex text line between NUM_REQ requesters, e.g. CPU MMIO register, switch mirror, debug/error code.
- Round-robin arbitration with a minimum on-screen hold time, counted in frames.
- The eight nibble outputs feed the VGA text renderer's s1..s8 inputs directly.
- All grant changes and digit updates occur only at frame start (falling edge of vs), so no tearing is visible mid-frame.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- HOLD_FRAMES, 60, minimum frames a grant is held before yielding to another pending requester; must be >=1.
- IDLE_CODE, 32'h0000_0000, word displayed when no requester is granted.

Ports:
- clk  input  1  system clock; same clock that drives the VGA renderer.
- rst  input  1  asynchronous, active-low reset.
- vs  input  1  vertical sync from the VGA renderer; active-low pulse; synchronous to clk.
- req  input  NUM_REQ  per-requester display request; level, held while the requester wants the screen.
- req_data  input  32*NUM_REQ  requester i word at bits [32*i+31 : 32*i].
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- frame_tick  output  1  one-clk pulse on each detected frame start.
- s1..s8  output  4 each  displayed digits; s1 = word[31:28] ... s8 = word[3:0].

Behaviour:
- Reset values (asynchronous on rst low):
  - state=IDLE, grant=0, frame_tick=0.
  - vs_q=1, hold_cnt=0.
  - rr_ptr=NUM_REQ-1, so the first pick is req0.
  - s1..s8 = nibbles of IDLE_CODE.
- Frame detect:
  - vs_q registers vs every clk.
  - fs = vs_q & ~vs, combinational.
  - frame_tick = registered fs, one clk later.
- Arbitration and display load: evaluated only in a cycle with fs=1. Outside fs, grant, state and s* hold.
- Round-robin pick: first set bit of req scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. On every new grant, rr_ptr <= granted index.
- IDLE:
  - At fs with any req set: grant the RR pick, state <= HOLD, hold_cnt <= 1.
  - At fs with req all zero: remain IDLE; s* reload IDLE_CODE.
- HOLD, owner k, evaluated at fs:
  - req[k]=0, others pending: grant the RR pick, hold_cnt <= 1.
  - req[k]=0, none pending: state <= IDLE, grant <= 0.
  - req[k]=1, hold_cnt==HOLD_FRAMES, another req pending: grant the RR pick, hold_cnt <= 1.
  - Otherwise: keep owner k; hold_cnt <= min(hold_cnt+1, HOLD_FRAMES), saturating.
- Display load:
  - In the same fs cycle, s* register the word selected by the next-state grant: req_data slice of the new owner, or IDLE_CODE if the next state is IDLE.
  - s* and grant become visible together one clk after the vs falling edge.
- req_data changes between frame starts are never visible until the next fs.
- A req pulse that rises and falls between two fs is ignored.
- grant is always one-hot or zero; never multi-hot.
- Reset asserted mid-operation: immediate return to reset values; the first grant after release waits for the next fs.

Optional Feature:
- Macro: VGA_TEXT_OWNER_TAG_EN.
- Defined: s1 shows the owner index (0..NUM_REQ-1) and s2..s8 show word[27:0] of the owner. In IDLE, s1 = 4'hF and s2..s8 = IDLE_CODE[27:0].
- Undefined: plain 8-nibble mapping as described under Behaviour.

Test Plan:
- Reset and idle: rst low, then released with req=0 and vs pulsing -> grant=0; s1..s8=0 every frame; frame_tick pulses once per vs falling edge.
- Single request: req=4'b0001, req_data[31:0]=32'h1234_ABCD set mid-frame -> s* stay 0 until the next vs fall. One clk after it: grant=0001, s1..s8 = 1,2,3,4,A,B,C,D.
- Round-robin with hold: HOLD_FRAMES=2, req=0101 continuously -> grant sequence per frame 0001,0001,0100,0100,0001,...
- Owner drop: owner 0 drops req, req2 pending -> grant=0100 at the next fs. Then all drop -> next fs: grant=0, s* = IDLE_CODE.
- No tearing and reset: req_data toggles every 10 clk during a frame -> s* change only at fs. rst low mid-HOLD -> s*=IDLE_CODE and grant=0 immediately.
- Tag option, VGA_TEXT_OWNER_TAG_EN defined: owner 2 with word 32'h0FED_CBA9 -> s1=2, s2..s8 = F,E,D,C,B,A,9. Idle -> s1=F.
